cnn_concat_256_48: RTL and testbench
====================================

Name: cnn_concat_256_48

Overview:
- Channel-concatenation stage directly upstream of the 304→256 1x1 convolution in the DeepLabV3+ decoder.
- Merges two independent pixel streams into one 304-channel stream in the order the 1x1 conv loop expects:
  - Stream A: 256-channel upsampled ASPP output.
  - Stream B: 48-channel low-level-feature 1x1 conv output.
- Both inputs are valid-only (no backpressure) and mutually unsynchronised, so each is buffered in its own FIFO.

Parameters:
- DATA_WIDTH, 32, word width of every pixel/channel sample.
- CH_A, 256, channels per pixel on stream A.
- CH_B, 48, channels per pixel on stream B.
- IMAGE_SIZE, 16384, pixels per frame (width×height).
- DEPTH_A, 512, stream-A FIFO depth in words; power of 2, ≥ CH_A.
- DEPTH_B, 2048, stream-B FIFO depth in words; power of 2; sized to absorb B running ahead of A.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_a_in  input  1  stream A word valid.
- pxl_a_in  input  DATA_WIDTH  stream A word; per pixel, channels 0..CH_A-1 in order.
- valid_b_in  input  1  stream B word valid.
- pxl_b_in  input  DATA_WIDTH  stream B word; per pixel, channels 0..CH_B-1 in order.
- pxl_out  output  DATA_WIDTH  concatenated word.
- valid_out  output  1  pxl_out valid.
- frame_done  output  1  one-cycle pulse with the last word of a frame.
- ovf_a  output  1  sticky: stream-A FIFO overflow occurred.
- ovf_b  output  1  sticky: stream-B FIFO overflow occurred.

Behaviour:
- Reset (reset=0, async):
  - Outputs: pxl_out=0, valid_out=0, frame_done=0, ovf_a=0, ovf_b=0.
  - FIFO pointers cleared, FSM=SEND_A, ch_cnt=0, pxl_cnt=0.
- Reset mid-frame discards all buffered data. After release, the first word accepted on A is channel 0 of pixel 0.
- FIFO write:
  - Push on valid_x_in.
  - Push when full with no pop in the same cycle: word dropped, ovf_x set (cleared only by reset).
  - Push when full with a pop in the same cycle: accepted.
- FSM with states SEND_A and SEND_B; ch_cnt counts words emitted in the current state.
  - SEND_A:
    - Pop A when A not empty; ch_cnt++.
    - At ch_cnt=CH_A-1 with pop: ch_cnt←0, go to SEND_B.
  - SEND_B:
    - Pop B when B not empty; ch_cnt++.
    - At ch_cnt=CH_B-1 with pop: ch_cnt←0, go to SEND_A, pxl_cnt++.
- Stall: while the FIFO for the current state is empty, no pop and valid_out=0. The other FIFO keeps filling; no reordering.
- Output register:
  - On a pop, pxl_out/valid_out are registered from FIFO head the next cycle (1-cycle pop-to-output latency).
  - Write-to-output latency on an empty FIFO in the matching state: 2 cycles (written at edge t, visible at t+1, output valid at t+2).
  - pxl_out holds its last value when valid_out=0.
- Frame counting:
  - frame_done=1 together with the valid_out of the word emitted on the last B pop of pixel IMAGE_SIZE-1.
  - pxl_cnt wraps to 0; the next frame starts in SEND_A without a gap.
- Throughput: 1 word/cycle sustained when data is available. No bubble at the A→B or B→A switch if the next FIFO is non-empty.
- Counter widths: ch_cnt $clog2(max(CH_A,CH_B)); pxl_cnt $clog2(IMAGE_SIZE).

Decomposition:
- Shared param include holds DATA_WIDTH, CH_A, CH_B, IMAGE_SIZE and derived widths (CH_CNT_WIDTH, PXL_CNT_WIDTH, PTR_WIDTH_A/B).
- One sub-module, concat_sync_fifo:
  - Parameterised DATA_WIDTH/DEPTH.
  - Registered-pointer synchronous FIFO with full/empty and a same-cycle push-on-full-with-pop rule.
  - Instantiated twice.
- FSM, counters and output register live in the top.

Test Plan (bench params CH_A=4, CH_B=2, IMAGE_SIZE=3, DEPTH_A=8, DEPTH_B=8):
- Interleaved order:
  - Stimulus: A words 0x10..0x13, then B 0x20,0x21.
  - Required: out 10,11,12,13,20,21; first valid_out 2 cycles after first A write; no gaps.
- B arrives first:
  - Stimulus: B 0x20,0x21 at cycle 0; A 0x10..0x13 from cycle 10.
  - Required: no valid_out before cycle 12; then 10..13,20,21 back-to-back.
- Full frame:
  - Stimulus: 3 pixels, A then B per pixel.
  - Required: 18 valid words in order; frame_done high only with the 18th; second frame starts with the next A word.
- Overflow:
  - Stimulus: 9 A words with no B, so state stalls in SEND_B after 4 pops.
  - Required: FIFO holds ≤8; no ovf_a (4 popped); then push 5 more with no pop → ovf_a=1, sticky until reset.
- Mid-frame reset:
  - Stimulus: assert reset after 3 output words.
  - Required: all outputs 0 asynchronously; after release, new A 0x30..0x33 + B 0x40,0x41 → out 30..33,40,41.
- Simultaneous full push/pop:
  - Stimulus: fill A FIFO to 8 in SEND_A with output stalled, then push and pop in the same cycle.
  - Required: word accepted, ovf_a stays 0, order preserved.

Source files
------------

// File: rtl/cnn_concat_256_48_pkg.sv
// Shared definitions for the 304-channel concatenation stage: default
// geometry, derived counter/pointer widths and the sequencer state type.
package cnn_concat_256_48_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CH_A       = 256;
  localparam int CH_B       = 48;
  localparam int IMAGE_SIZE = 16384;
  localparam int DEPTH_A    = 512;
  localparam int DEPTH_B    = 2048;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Larger of two channel counts, used to size the shared channel counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CH_CNT_WIDTH  = cnt_width(max_int(CH_A, CH_B));
  localparam int PXL_CNT_WIDTH = cnt_width(IMAGE_SIZE);
  localparam int PTR_WIDTH_A   = cnt_width(DEPTH_A);
  localparam int PTR_WIDTH_B   = cnt_width(DEPTH_B);

  // Which input stream the output is currently draining.
  typedef enum logic {
    SEND_A = 1'b0,
    SEND_B = 1'b1
  } state_t;

endpackage

// File: rtl/concat_sync_fifo.sv
// Single-clock FIFO with registered read/write pointers and combinational
// head-of-queue output. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise the word is dropped and the
// sticky overflow flag is raised until reset.
module concat_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  ovf
);

  localparam int ADDR_WIDTH = cnn_concat_256_48_pkg::cnt_width(DEPTH);

  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  full;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Pointer advance and sticky overflow capture.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop_ok) ovf <= 1'b1;
    end
  end

  // Storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; clearing the pointers empties the FIFO.
    if (push_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/cnn_concat_256_48.sv
// Channel concatenation ahead of the 304->256 1x1 convolution: each pixel is
// emitted as CH_A words from stream A followed by CH_B words from stream B.
// Both streams are buffered independently; the sequencer stalls on an empty
// source FIFO and never reorders words.
module cnn_concat_256_48 #(
  parameter int DATA_WIDTH = cnn_concat_256_48_pkg::DATA_WIDTH,
  parameter int CH_A       = cnn_concat_256_48_pkg::CH_A,
  parameter int CH_B       = cnn_concat_256_48_pkg::CH_B,
  parameter int IMAGE_SIZE = cnn_concat_256_48_pkg::IMAGE_SIZE,
  parameter int DEPTH_A    = cnn_concat_256_48_pkg::DEPTH_A,
  parameter int DEPTH_B    = cnn_concat_256_48_pkg::DEPTH_B
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_a_in,
  input  logic [DATA_WIDTH-1:0] pxl_a_in,
  input  logic                  valid_b_in,
  input  logic [DATA_WIDTH-1:0] pxl_b_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  ovf_a,
  output logic                  ovf_b
);

  import cnn_concat_256_48_pkg::*;

  localparam int CH_W  = cnt_width(max_int(CH_A, CH_B));
  localparam int PXL_W = cnt_width(IMAGE_SIZE);

  localparam logic [CH_W-1:0]  CH_A_LAST = CH_W'(CH_A - 1);
  localparam logic [CH_W-1:0]  CH_B_LAST = CH_W'(CH_B - 1);
  localparam logic [PXL_W-1:0] PXL_LAST  = PXL_W'(IMAGE_SIZE - 1);

  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic                  empty_a;
  logic                  empty_b;
  logic                  pop_a;
  logic                  pop_b;
  logic                  frame_end;

  state_t           state_q;
  state_t           state_d;
  logic [CH_W-1:0]  ch_cnt_q;
  logic [CH_W-1:0]  ch_cnt_d;
  logic [PXL_W-1:0] pxl_cnt_q;
  logic [PXL_W-1:0] pxl_cnt_d;

  concat_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH_A)
  ) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .push  (valid_a_in),
    .din   (pxl_a_in),
    .pop   (pop_a),
    .dout  (head_a),
    .empty (empty_a),
    .ovf   (ovf_a)
  );

  concat_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH_B)
  ) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .push  (valid_b_in),
    .din   (pxl_b_in),
    .pop   (pop_b),
    .dout  (head_b),
    .empty (empty_b),
    .ovf   (ovf_b)
  );

  // Sequencer state and channel/pixel counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEND_A;
      ch_cnt_q  <= '0;
      pxl_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pxl_cnt_q <= pxl_cnt_d;
    end
  end

  // Pop decision and next-state: drain CH_A words of A, then CH_B words of B.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pxl_cnt_d = pxl_cnt_q;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      SEND_A: begin
        if (!empty_a) begin
          pop_a = 1'b1;
          if (ch_cnt_q == CH_A_LAST) begin
            ch_cnt_d = '0;
            state_d  = SEND_B;
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end
      SEND_B: begin
        if (!empty_b) begin
          pop_b = 1'b1;
          if (ch_cnt_q == CH_B_LAST) begin
            ch_cnt_d = '0;
            state_d  = SEND_A;
            if (pxl_cnt_q == PXL_LAST) begin
              pxl_cnt_d = '0;
              frame_end = 1'b1;
            end else begin
              pxl_cnt_d = pxl_cnt_q + 1'b1;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SEND_A;
    endcase
  end

  // Output register: capture the popped head word; data holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= pop_a || pop_b;
      frame_done <= frame_end;
      if (pop_a) begin
        pxl_out <= head_a;
      end else if (pop_b) begin
        pxl_out <= head_b;
      end
    end
  end

endmodule

// File: tb/tb_cnn_concat_256_48.sv
// Scoreboard bench for the channel concatenation stage with a small geometry
// (4+2 channels, 3 pixels, 8-deep FIFOs). Stimulus pushes expected words in
// output order; a negedge monitor pops and compares every valid output.
module tb_cnn_concat_256_48;

  localparam int DW          = 32;
  localparam int CH_A        = 4;
  localparam int CH_B        = 2;
  localparam int IMG         = 3;
  localparam int FRAME_WORDS = (CH_A + CH_B) * IMG;

  typedef struct {
    logic [DW-1:0] data;
    logic          fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_a_in = 1'b0;
  logic [DW-1:0] pxl_a_in = '0;
  logic          valid_b_in = 1'b0;
  logic [DW-1:0] pxl_b_in = '0;
  logic [DW-1:0] pxl_out;
  logic          valid_out;
  logic          frame_done;
  logic          ovf_a;
  logic          ovf_b;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_idx = 0;
  int   n_out   = 0;
  int   first_v = -1;
  int   last_v  = -1;
  int   cyc     = 0;
  int   t0      = 0;

  cnn_concat_256_48 #(
    .DATA_WIDTH (DW),
    .CH_A       (CH_A),
    .CH_B       (CH_B),
    .IMAGE_SIZE (IMG),
    .DEPTH_A    (8),
    .DEPTH_B    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_a_in (valid_a_in),
    .pxl_a_in   (pxl_a_in),
    .valid_b_in (valid_b_in),
    .pxl_b_in   (pxl_b_in),
    .pxl_out    (pxl_out),
    .valid_out  (valid_out),
    .frame_done (frame_done),
    .ovf_a      (ovf_a),
    .ovf_b      (ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame_done comes from the word's position within the frame.
  task automatic push_exp(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.fd   = (exp_idx == FRAME_WORDS - 1);
    exp_q.push_back(e);
    exp_idx = (exp_idx + 1) % FRAME_WORDS;
  endtask

  task automatic drive(input logic va, input logic [DW-1:0] da,
                       input logic vb, input logic [DW-1:0] db);
    @(negedge clk);
    valid_a_in = va;
    pxl_a_in   = da;
    valid_b_in = vb;
    pxl_b_in   = db;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      drive(1'b0, '0, 1'b0, '0);
      #1;
      k++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset      = 1'b0;
    valid_a_in = 1'b0;
    valid_b_in = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_idx = 0;
    reset   = 1'b1;
    n_out   = 0;
    first_v = -1;
    last_v  = -1;
  endtask

  // Monitor: compare every presented output word against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (frame_done && !valid_out) check("fd_without_valid", valid_out, 1);
      if (valid_out) begin
        n_out++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got 0x%0h, no word expected (cycle %0d)", pxl_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_data", pxl_out, e.data);
          check("out_frame_done", frame_done, e.fd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset values.
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pxl_out", pxl_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_ovf_b", ovf_b, 0);
    reset = 1'b1;

    // Interleaved order: A then B, back-to-back.
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(32'h10 + i);
    push_exp(32'h20);
    push_exp(32'h21);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i, 1'b0, '0);
      if (i == 0) t0 = cyc;
    end
    drive(1'b0, '0, 1'b1, 32'h20);
    drive(1'b0, '0, 1'b1, 32'h21);
    wait_drain("t1", 30);
    check("t1_first_latency", first_v - t0, 2);
    check("t1_no_gaps", last_v - first_v, 5);

    // B arrives first; A ten cycles later.
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(32'h10 + i);
    push_exp(32'h20);
    push_exp(32'h21);
    drive(1'b0, '0, 1'b1, 32'h20);
    t0 = cyc;
    drive(1'b0, '0, 1'b1, 32'h21);
    idle(8);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + i, 1'b0, '0);
    wait_drain("t2", 30);
    check("t2_first_valid_cycle", first_v - t0, 12);
    check("t2_no_gaps", last_v - first_v, 5);

    // Full frame plus first pixel of the next frame.
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) push_exp(32'h100 + p * 16 + c);
      for (int c = 0; c < 2; c++) push_exp(32'h200 + p * 16 + c);
    end
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) drive(1'b1, 32'h100 + p * 16 + c, 1'b0, '0);
      for (int c = 0; c < 2; c++) drive(1'b0, '0, 1'b1, 32'h200 + p * 16 + c);
    end
    wait_drain("t3", 40);
    check("t3_words", n_out, 24);
    check("t3_no_gaps", last_v - first_v, 23);
    check("t3_ovf_a", ovf_a, 0);

    // Overflow on stream A while stalled in SEND_B.
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(32'h50 + i);
    for (int i = 0; i < 9; i++) drive(1'b1, 32'h50 + i, 1'b0, '0);
    wait_drain("t4a", 30);
    check("t4_no_ovf_a_yet", ovf_a, 0);
    check("t4_no_ovf_b", ovf_b, 0);
    for (int i = 9; i < 14; i++) drive(1'b1, 32'h50 + i, 1'b0, '0);
    idle(2);
    check("t4_ovf_a_set", ovf_a, 1);
    check("t4_ovf_b_clear", ovf_b, 0);
    push_exp(32'h20);
    push_exp(32'h21);
    for (int i = 4; i < 8; i++) push_exp(32'h50 + i);
    drive(1'b0, '0, 1'b1, 32'h20);
    drive(1'b0, '0, 1'b1, 32'h21);
    wait_drain("t4b", 30);
    idle(5);
    check("t4_ovf_a_sticky", ovf_a, 1);
    apply_reset();
    #1;
    check("t4_ovf_a_after_reset", ovf_a, 0);

    // Mid-frame reset after three output words.
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(32'h10 + i);
    push_exp(32'h20);
    push_exp(32'h21);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + i, 1'b0, '0);
    k = 0;
    while (n_out < 3 && k < 20) begin
      drive(1'b0, '0, 1'b0, '0);
      #1;
      k++;
    end
    check("t5_three_out", n_out, 3);
    reset = 1'b0;
    #1;
    check("t5_async_pxl_out", pxl_out, 0);
    check("t5_async_valid_out", valid_out, 0);
    check("t5_async_frame_done", frame_done, 0);
    check("t5_async_ovf_a", ovf_a, 0);
    check("t5_async_ovf_b", ovf_b, 0);
    exp_q.delete();
    exp_idx = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'h30 + i);
    push_exp(32'h40);
    push_exp(32'h41);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h30 + i, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'h40);
    drive(1'b0, '0, 1'b1, 32'h41);
    wait_drain("t5", 30);

    // Push into a full A FIFO in the same cycle as a pop.
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(32'h60 + i);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h60 + i, 1'b0, '0);
    wait_drain("t6a", 30);
    for (int i = 4; i < 12; i++) drive(1'b1, 32'h60 + i, 1'b0, '0);
    idle(2);
    check("t6_full_no_ovf", ovf_a, 0);
    push_exp(32'h70);
    push_exp(32'h71);
    for (int i = 4; i < 8; i++) push_exp(32'h60 + i);
    drive(1'b0, '0, 1'b1, 32'h70);
    drive(1'b0, '0, 1'b1, 32'h71);
    idle(1);
    drive(1'b1, 32'h6C, 1'b0, '0);
    wait_drain("t6b", 30);
    check("t6_push_pop_no_ovf", ovf_a, 0);
    push_exp(32'h72);
    push_exp(32'h73);
    for (int i = 8; i < 12; i++) push_exp(32'h60 + i);
    drive(1'b0, '0, 1'b1, 32'h72);
    drive(1'b0, '0, 1'b1, 32'h73);
    wait_drain("t6c", 30);
    push_exp(32'h74);
    push_exp(32'h75);
    push_exp(32'h6C);
    drive(1'b0, '0, 1'b1, 32'h74);
    drive(1'b0, '0, 1'b1, 32'h75);
    wait_drain("t6d", 30);
    check("t6_final_ovf_a", ovf_a, 0);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
